tport_arbiter_2x1: RTL and testbench

//  Shares one request/response target port (e.g. the boot ROM) between two masters:
//  m0 = instruction fetch, m1 = data/debug.

---
 rtl/tport_pkg.sv | 27 ++
 rtl/tport_id_fifo.sv | 63 ++++++
 rtl/tport_arbiter_2x1.sv | 134 +++++++++++++
 tb/tb_tport_arbiter_2x1.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tport_pkg.sv
// Shared types and constants for the shared target-port arbiter.
package tport_pkg;

    localparam int TPORT_ADDR_W = 32;
    localparam int TPORT_DATA_W = 32;

    // Privilege encodings carried on treqpriv
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    // Master identifier: 0 = instruction fetch, 1 = data/debug
    typedef logic tport_mid_t;
    localparam tport_mid_t MID_FETCH = 1'b0;
    localparam tport_mid_t MID_DATA  = 1'b1;

    typedef struct packed {
        logic [1:0]              priv;
        logic [TPORT_ADDR_W-1:0] addr;
    } tport_req_t;

    typedef struct packed {
        logic                    rerr;
        logic [TPORT_DATA_W-1:0] data;
    } tport_rsp_t;

endpackage

// File: rtl/tport_id_fifo.sv
// Small FIFO holding the master ID of every accepted-but-unanswered request.
// Push is refused while full and pop while empty; a pop never frees room for
// a push in the same cycle.
module tport_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rptr_q];

    // Next pointer/count values; power-of-two depth lets pointers wrap naturally
    always_comb begin
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + PTR_W'(1);
        if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
        if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents are meaningless while empty so it is not reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/tport_arbiter_2x1.sv
// Shares one request/response target port between a fetch master (m0) and a
// data/debug master (m1). Requests are arbitrated round-robin with a hold that
// keeps the grant stable across a stalled handshake; responses come back in
// order and are steered by an outstanding-ID FIFO. No cycles are added.
module tport_arbiter_2x1 #(
    parameter int C_OUTSTANDING = 4,
    parameter int C_ADDR_W      = 32,
    parameter int C_DATA_W      = 32
) (
    input  logic                clk,
    input  logic                resetb,
    // master 0 (fetch)
    output logic                m0_treqready,
    input  logic                m0_treqvalid,
    input  logic [1:0]          m0_treqpriv,
    input  logic [C_ADDR_W-1:0] m0_treqaddr,
    input  logic                m0_trspready,
    output logic                m0_trspvalid,
    output logic                m0_trsprerr,
    output logic [C_DATA_W-1:0] m0_trspdata,
    // master 1 (data/debug)
    output logic                m1_treqready,
    input  logic                m1_treqvalid,
    input  logic [1:0]          m1_treqpriv,
    input  logic [C_ADDR_W-1:0] m1_treqaddr,
    input  logic                m1_trspready,
    output logic                m1_trspvalid,
    output logic                m1_trsprerr,
    output logic [C_DATA_W-1:0] m1_trspdata,
    // shared slave
    input  logic                s_treqready,
    output logic                s_treqvalid,
    output logic [1:0]          s_treqpriv,
    output logic [C_ADDR_W-1:0] s_treqaddr,
    output logic                s_trspready,
    input  logic                s_trspvalid,
    input  logic                s_trsprerr,
    input  logic [C_DATA_W-1:0] s_trspdata,
    output logic                stray_rsp
);

    import tport_pkg::*;

    tport_mid_t gnt;
    tport_mid_t head_id;
    tport_mid_t rr_last_q, rr_last_d;
    tport_mid_t held_q, held_d;
    logic       hold_q, hold_d;
    logic       stray_q, stray_d;
    logic       fifo_full, fifo_empty;
    logic       gnt_valid;
    logic       accept;
    logic       pop;
    logic       head_ready;

    // Grant select: a stalled handshake keeps its master, otherwise round-robin
    always_comb begin
        if (hold_q)                          gnt = held_q;
        else if (m0_treqvalid && !m1_treqvalid) gnt = MID_FETCH;
        else if (m1_treqvalid && !m0_treqvalid) gnt = MID_DATA;
        else                                 gnt = ~rr_last_q;
    end

    // Request path mux; a full ID FIFO blocks forwarding entirely
    always_comb begin
        gnt_valid    = (gnt == MID_DATA) ? m1_treqvalid : m0_treqvalid;
        s_treqvalid  = gnt_valid & ~fifo_full;
        s_treqpriv   = (gnt == MID_DATA) ? m1_treqpriv : m0_treqpriv;
        s_treqaddr   = (gnt == MID_DATA) ? m1_treqaddr : m0_treqaddr;
        m0_treqready = (gnt == MID_FETCH) & s_treqready & ~fifo_full;
        m1_treqready = (gnt == MID_DATA)  & s_treqready & ~fifo_full;
        accept       = s_treqvalid & s_treqready;
    end

    // Arbitration state: remember the last winner, pin the grant while stalled
    always_comb begin
        rr_last_d = rr_last_q;
        hold_d    = hold_q;
        held_d    = held_q;
        if (accept) begin
            rr_last_d = gnt;
            hold_d    = 1'b0;
        end else if (s_treqvalid) begin
            hold_d = 1'b1;
            held_d = gnt;
        end
    end

    // Response routing by FIFO head; with nothing outstanding the slave is sunk
    always_comb begin
        head_ready   = (head_id == MID_DATA) ? m1_trspready : m0_trspready;
        m0_trspvalid = s_trspvalid & ~fifo_empty & (head_id == MID_FETCH);
        m1_trspvalid = s_trspvalid & ~fifo_empty & (head_id == MID_DATA);
        s_trspready  = fifo_empty ? 1'b1 : head_ready;
        m0_trsprerr  = s_trsprerr;
        m1_trsprerr  = s_trsprerr;
        m0_trspdata  = s_trspdata;
        m1_trspdata  = s_trspdata;
        pop          = s_trspvalid & s_trspready & ~fifo_empty;
        stray_d      = s_trspvalid & fifo_empty;
    end

    assign stray_rsp = stray_q;

    // Control registers; rr_last resets to m1 so m0 wins the first tie
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            rr_last_q <= MID_DATA;
            hold_q    <= 1'b0;
            held_q    <= MID_FETCH;
            stray_q   <= 1'b0;
        end else begin
            rr_last_q <= rr_last_d;
            hold_q    <= hold_d;
            held_q    <= held_d;
            stray_q   <= stray_d;
        end
    end

    tport_id_fifo #(
        .DEPTH (C_OUTSTANDING),
        .WIDTH (1)
    ) u_id_fifo (
        .clk    (clk),
        .resetb (resetb),
        .push   (accept),
        .pop    (pop),
        .din    (gnt),
        .head   (head_id),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

endmodule

// File: tb/tb_tport_arbiter_2x1.sv
// Bench for tport_arbiter_2x1: directed scenarios plus a random soak, all
// checked every cycle against a queue-based reference model of the port.
module tb_tport_arbiter_2x1;
    import tport_pkg::*;

    localparam int NOUT = 4;

    logic        clk = 1'b0;
    logic        resetb;
    always #5 clk = ~clk;

    logic        m0_treqready, m1_treqready;
    logic        m0_trspvalid, m1_trspvalid;
    logic        m0_trsprerr, m1_trsprerr;
    logic [31:0] m0_trspdata, m1_trspdata;
    logic        s_treqvalid, s_trspready, stray_rsp;
    logic [1:0]  s_treqpriv;
    logic [31:0] s_treqaddr;

    logic        mv [2];
    logic [1:0]  mpriv [2];
    logic [31:0] maddr [2];
    logic        mrr [2];
    logic        s_treqready, s_trspvalid, s_trsprerr;
    logic [31:0] s_trspdata;

    tport_arbiter_2x1 #(.C_OUTSTANDING(NOUT), .C_ADDR_W(32), .C_DATA_W(32)) dut (
        .clk(clk), .resetb(resetb),
        .m0_treqready(m0_treqready), .m0_treqvalid(mv[0]), .m0_treqpriv(mpriv[0]),
        .m0_treqaddr(maddr[0]), .m0_trspready(mrr[0]), .m0_trspvalid(m0_trspvalid),
        .m0_trsprerr(m0_trsprerr), .m0_trspdata(m0_trspdata),
        .m1_treqready(m1_treqready), .m1_treqvalid(mv[1]), .m1_treqpriv(mpriv[1]),
        .m1_treqaddr(maddr[1]), .m1_trspready(mrr[1]), .m1_trspvalid(m1_trspvalid),
        .m1_trsprerr(m1_trsprerr), .m1_trspdata(m1_trspdata),
        .s_treqready(s_treqready), .s_treqvalid(s_treqvalid), .s_treqpriv(s_treqpriv),
        .s_treqaddr(s_treqaddr), .s_trspready(s_trspready), .s_trspvalid(s_trspvalid),
        .s_trsprerr(s_trsprerr), .s_trspdata(s_trspdata), .stray_rsp(stray_rsp)
    );

    // reference model state
    bit          id_q [$];
    tport_rsp_t  exp_rsp0 [$];
    tport_rsp_t  exp_rsp1 [$];
    logic [31:0] slave_q [$];
    bit          rr_last, hold, held, stray_exp;

    int checks, errors;
    int acc_cnt [2];
    int dlv_cnt [2];
    int stray_cnt;
    bit glog [$];

    int srdy_mode, rsp_mode, rrdy_mode, m_prob;
    int req_left [2];
    logic [31:0] next_addr [2];
    logic [1:0]  plist [3];

    function automatic tport_rsp_t rom(input logic [31:0] a);
        tport_rsp_t r;
        r.rerr = a[4] & a[5];
        r.data = {~a[15:0], a[15:0]} ^ 32'h5A5A_0F0F;
        return r;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        id_q.delete();
        exp_rsp0.delete();
        exp_rsp1.delete();
        rr_last   = 1'b1;
        hold      = 1'b0;
        held      = 1'b0;
        stray_exp = 1'b0;
    endtask

    // One clock cycle: compare all outputs with the model, then advance the model.
    task automatic step();
        bit g, h, full, empty, exp_sv, exp_srdy, acc, popq, srv;
        tport_rsp_t er;
        #1;
        full  = (id_q.size() == NOUT);
        empty = (id_q.size() == 0);
        if (hold)                   g = held;
        else if (mv[0] && !mv[1])   g = 1'b0;
        else if (mv[1] && !mv[0])   g = 1'b1;
        else                        g = !rr_last;
        exp_sv = mv[g] && !full;
        chk1("s_treqvalid", s_treqvalid, exp_sv);
        if (exp_sv) begin
            chkw("s_treqaddr", s_treqaddr, maddr[g]);
            chkw("s_treqpriv", 32'(s_treqpriv), 32'(mpriv[g]));
        end
        if (mv[0] || mv[1]) begin
            chk1("m0_treqready", m0_treqready, !g && s_treqready && !full);
            chk1("m1_treqready", m1_treqready, g && s_treqready && !full);
        end
        acc      = exp_sv && s_treqready;
        h        = empty ? 1'b0 : id_q[0];
        exp_srdy = empty ? 1'b1 : mrr[h];
        srv      = s_trspvalid;
        chk1("s_trspready", s_trspready, exp_srdy);
        chk1("m0_trspvalid", m0_trspvalid, srv && !empty && !h);
        chk1("m1_trspvalid", m1_trspvalid, srv && !empty && h);
        if (srv && !empty) begin
            er = h ? exp_rsp1[0] : exp_rsp0[0];
            chkw("trspdata", h ? m1_trspdata : m0_trspdata, er.data);
            chk1("trsprerr", h ? m1_trsprerr : m0_trsprerr, er.rerr);
        end
        chk1("stray_rsp", stray_rsp, stray_exp);
        popq = srv && exp_srdy && !empty;
        if (mv[0] && m0_treqready) acc_cnt[0]++;
        if (mv[1] && m1_treqready) acc_cnt[1]++;
        if (m0_trspvalid && mrr[0]) dlv_cnt[0]++;
        if (m1_trspvalid && mrr[1]) dlv_cnt[1]++;
        if (stray_rsp) stray_cnt++;
        if (acc) glog.push_back(g);
        @(posedge clk);
        #1;
        stray_exp = srv && empty;
        if (srv && exp_srdy && slave_q.size() > 0) void'(slave_q.pop_front());
        if (popq) begin
            void'(id_q.pop_front());
            if (h) void'(exp_rsp1.pop_front());
            else   void'(exp_rsp0.pop_front());
        end
        if (acc) begin
            id_q.push_back(g);
            slave_q.push_back(maddr[g]);
            if (g) exp_rsp1.push_back(rom(maddr[g]));
            else   exp_rsp0.push_back(rom(maddr[g]));
            rr_last = g;
            hold    = 1'b0;
            mv[g]   = 1'b0;
        end else if (exp_sv) begin
            hold = 1'b1;
            held = g;
        end
    endtask

    // Drive masters and the ROM slave according to the current knobs.
    task automatic auto_drive();
        tport_rsp_t r;
        for (int n = 0; n < 2; n++) begin
            if (!mv[n] && req_left[n] > 0 && int'($urandom_range(99)) < m_prob) begin
                mv[n]        = 1'b1;
                maddr[n]     = next_addr[n];
                next_addr[n] = next_addr[n] + 32'd4;
                mpriv[n]     = (n == 0) ? PRIV_M : plist[$urandom_range(2)];
                req_left[n]--;
            end
            mrr[n] = (rrdy_mode == 2) ? 1'($urandom_range(1)) : (rrdy_mode == 1);
        end
        s_treqready = (srdy_mode == 2) ? 1'($urandom_range(1)) : (srdy_mode == 1);
        if (slave_q.size() > 0 && (rsp_mode == 1 || (rsp_mode == 2 && $urandom_range(1) == 1))) begin
            r           = rom(slave_q[0]);
            s_trspvalid = 1'b1;
            s_trspdata  = r.data;
            s_trsprerr  = r.rerr;
        end else begin
            s_trspvalid = 1'b0;
            s_trspdata  = $urandom;
            s_trsprerr  = 1'b0;
        end
    endtask

    task automatic tick();
        step();
        auto_drive();
    endtask

    task automatic drain();
        int n;
        n = 0;
        srdy_mode = 1; rsp_mode = 1; rrdy_mode = 1;
        req_left[0] = 0; req_left[1] = 0;
        auto_drive();
        while ((id_q.size() > 0 || mv[0] || mv[1] || slave_q.size() > 0) && n < 200) begin
            tick();
            n++;
        end
        chk1("drain_done", n < 200, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, d0, d1, st;
        bit first;
        tport_rsp_t r;
        checks = 0; errors = 0; stray_cnt = 0;
        plist[0] = PRIV_U; plist[1] = PRIV_S; plist[2] = PRIV_M;
        for (int n = 0; n < 2; n++) begin
            mv[n] = 1'b0; mpriv[n] = 2'b00; maddr[n] = '0; mrr[n] = 1'b1;
            acc_cnt[n] = 0; dlv_cnt[n] = 0; req_left[n] = 0; next_addr[n] = '0;
        end
        s_treqready = 1'b0; s_trspvalid = 1'b0; s_trsprerr = 1'b0; s_trspdata = '0;
        srdy_mode = 1; rsp_mode = 1; rrdy_mode = 1; m_prob = 100;
        resetb = 1'b0;
        model_reset();

        // reset state
        #2;
        chk1("rst_s_treqvalid", s_treqvalid, 1'b0);
        chk1("rst_m0_trspvalid", m0_trspvalid, 1'b0);
        chk1("rst_m1_trspvalid", m1_trspvalid, 1'b0);
        chk1("rst_stray", stray_rsp, 1'b0);
        chk1("rst_s_trspready", s_trspready, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        resetb = 1'b1;

        // A: m0 alone fetches 0x0,0x4,0x8 back to back
        a0 = acc_cnt[0]; d0 = dlv_cnt[0]; d1 = dlv_cnt[1];
        req_left[0] = 3; next_addr[0] = 32'h0;
        auto_drive();
        for (int i = 0; i < 3; i++) tick();
        chki("A_back_to_back", acc_cnt[0] - a0, 3);
        drain();
        chki("A_m0_rsp", dlv_cnt[0] - d0, 3);
        chki("A_m1_rsp", dlv_cnt[1] - d1, 0);

        // B: both masters valid every cycle -> alternating grants
        glog.delete();
        first = !rr_last;
        a0 = acc_cnt[0]; a1 = acc_cnt[1]; d0 = dlv_cnt[0]; d1 = dlv_cnt[1];
        req_left[0] = 6; req_left[1] = 6; next_addr[1] = 32'h8000;
        rsp_mode = 2;
        auto_drive();
        for (int i = 0; i < 12; i++) tick();
        drain();
        chki("B_accepts", glog.size(), 12);
        for (int i = 0; i < glog.size(); i++)
            chk1("B_alternate", glog[i], first ^ 1'(i));
        chki("B_m0_in_order", dlv_cnt[0] - d0, acc_cnt[0] - a0);
        chki("B_m1_in_order", dlv_cnt[1] - d1, acc_cnt[1] - a1);

        // C: slave stalls while m1 holds the grant; m0 arrives and waits
        a0 = acc_cnt[0]; a1 = acc_cnt[1];
        s_treqready = 1'b0; s_trspvalid = 1'b0;
        mv[1] = 1'b1; maddr[1] = 32'h100; mpriv[1] = PRIV_U;
        step();
        mv[0] = 1'b1; maddr[0] = 32'h200; mpriv[0] = PRIV_M;
        for (int i = 0; i < 2; i++) begin
            #1;
            chkw("C_addr_held", s_treqaddr, 32'h100);
            chk1("C_m0_wait", m0_treqready, 1'b0);
            step();
        end
        s_treqready = 1'b1;
        step();
        chki("C_m1_accept", acc_cnt[1] - a1, 1);
        chki("C_m0_not_yet", acc_cnt[0] - a0, 0);
        step();
        chki("C_m0_accept", acc_cnt[0] - a0, 1);
        drain();

        // D: fill all outstanding slots, then free exactly one
        rsp_mode = 0; req_left[0] = 5; next_addr[0] = 32'h1000;
        auto_drive();
        for (int i = 0; i < 5; i++) tick();
        #1;
        chk1("D_5th_blocked", m0_treqready, 1'b0);
        chk1("D_5th_not_fwd", s_treqvalid, 1'b0);
        r = rom(slave_q[0]);
        s_trspvalid = 1'b1; s_trspdata = r.data; s_trsprerr = r.rerr;
        #1;
        chk1("D_no_full_bypass", m0_treqready, 1'b0);
        step();
        s_trspvalid = 1'b0;
        #1;
        chk1("D_slot_freed", m0_treqready, 1'b1);
        step();
        drain();

        // E: head response for m1 stalled by m1_trspready=0
        d0 = dlv_cnt[0]; d1 = dlv_cnt[1];
        s_treqready = 1'b1; s_trspvalid = 1'b0;
        mv[1] = 1'b1; maddr[1] = 32'h300; mpriv[1] = PRIV_S;
        step();
        mv[0] = 1'b1; maddr[0] = 32'h400; mpriv[0] = PRIV_M;
        step();
        r = rom(32'h300);
        mrr[1] = 1'b0; mrr[0] = 1'b1;
        s_trspvalid = 1'b1; s_trspdata = r.data; s_trsprerr = r.rerr;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("E_s_trspready", s_trspready, 1'b0);
            chk1("E_m0_not_early", m0_trspvalid, 1'b0);
            chkw("E_data_held", m1_trspdata, r.data);
            step();
        end
        mrr[1] = 1'b1;
        step();
        drain();
        chki("E_m1_rsp", dlv_cnt[1] - d1, 1);
        chki("E_m0_rsp", dlv_cnt[0] - d0, 1);

        // F: response with nothing outstanding
        s_trspvalid = 1'b1; s_trspdata = 32'hDEAD_BEEF; s_trsprerr = 1'b0;
        step();
        s_trspvalid = 1'b0;
        #1;
        chk1("F_stray_pulse", stray_rsp, 1'b1);
        step();
        #1;
        chk1("F_stray_clear", stray_rsp, 1'b0);

        // G: reset with two requests outstanding, late responses become stray
        rsp_mode = 0; req_left[0] = 2; next_addr[0] = 32'h2000;
        auto_drive();
        for (int i = 0; i < 3; i++) tick();
        r = rom(slave_q[0]);
        s_trspvalid = 1'b1; s_trspdata = r.data; s_trsprerr = r.rerr;
        #1;
        chk1("G_pre_rst_m0_trspvalid", m0_trspvalid, 1'b1);
        resetb = 1'b0;
        #1;
        chk1("G_rst_s_treqvalid", s_treqvalid, 1'b0);
        chk1("G_rst_m0_trspvalid", m0_trspvalid, 1'b0);
        chk1("G_rst_m1_trspvalid", m1_trspvalid, 1'b0);
        chk1("G_rst_s_trspready", s_trspready, 1'b1);
        model_reset();
        s_trspvalid = 1'b0;
        @(posedge clk); #1;
        resetb = 1'b1;
        chk1("G_rst_stray", stray_rsp, 1'b0);
        st = stray_cnt;
        rsp_mode = 1;
        auto_drive();
        for (int i = 0; i < 4; i++) tick();
        chki("G_late_strays", stray_cnt - st, 2);
        mv[0] = 1'b1; maddr[0] = 32'h500; mpriv[0] = PRIV_M;
        mv[1] = 1'b1; maddr[1] = 32'h600; mpriv[1] = PRIV_S;
        s_treqready = 1'b1;
        #1;
        chk1("G_first_tie_m0", m0_treqready, 1'b1);
        chk1("G_first_tie_m1", m1_treqready, 1'b0);
        drain();

        // R: random soak
        a0 = acc_cnt[0]; a1 = acc_cnt[1]; d0 = dlv_cnt[0]; d1 = dlv_cnt[1];
        req_left[0] = 200; req_left[1] = 200; m_prob = 50;
        next_addr[0] = 32'h4000; next_addr[1] = 32'hC000;
        srdy_mode = 2; rsp_mode = 2; rrdy_mode = 2;
        auto_drive();
        for (int i = 0; i < 1500; i++) tick();
        drain();
        chki("R_m0_all_rsp", dlv_cnt[0] - d0, acc_cnt[0] - a0);
        chki("R_m1_all_rsp", dlv_cnt[1] - d1, acc_cnt[1] - a1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
